not_gate_vector_checker: RTL

- Self-contained stimulus generator and response checker for the multi-output inverter cosim target.
- Drives pseudo-random 128-bit vectors into the target's input bus and captures the target's 128-bit output bus after a fixed latency.
- Compares each captured response against an internal reference model, then reports a pass/fail summary.
- Sits in the cosim harness opposite the target: it writes `in` and reads `out`.

---
 rtl/not_gate_vector_checker.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/not_gate_vector_checker.sv
// not_gate_vector_checker: drives LFSR stimulus into the multi-output
// inverter target and checks its response after a fixed latency.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          pulse, begins a run from IDLE or DONE
//   dut_in         stimulus vector to the target
//   dut_out        target response
//   busy           high while issuing or draining
//   done           high once a run has finished, until the next start
//   pass           valid with done; 1 when no mismatches were seen
//   err_count      saturating mismatch count
//   first_err_idx  index of the first mismatching vector, 16'hFFFF if none
module not_gate_vector_checker #(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned NUM_VECS = 256,
  parameter int unsigned DUT_LAT  = 1,
  parameter logic [31:0] SEED     = 32'hACE1_2015
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LFSR_W  = 32;
  localparam int unsigned DRAIN_W = 4;
  localparam int unsigned REP     = WIDTH / LFSR_W + 1;

  localparam logic [LFSR_W-1:0]  LFSR_TAPS  = 32'h8020_0003;
  localparam logic [CNT_W-1:0]   NO_ERR     = 16'hFFFF;
  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_VECS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] exp;
  } chk_t;

  // Galois step for x^32+x^22+x^2+x+1 (right-shifting form).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // LFSR state repeated across the bus, low bits kept.
  function automatic logic [WIDTH-1:0] replicate(input logic [LFSR_W-1:0] s);
    return WIDTH'({REP{s}});
  endfunction

  // Expected target response for an issued vector.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] e;
    e    = '0;
    e[0] = ~v[0];
    e[1] = ~v[1];
    e[2] = ~v[2];
    e[3] = ~v[2];
    e[4] = ~v[3];
    e[5] = ~v[3];
    return e;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   dut_in_q, dut_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;

  chk_t issue_c;
  chk_t cmp_c;
  logic mismatch_c;

  // Entry describing the vector currently on dut_in.
  always_comb begin
    issue_c.valid = (state_q == S_RUN);
    issue_c.idx   = idx_q;
    issue_c.exp   = ref_model(dut_in_q);
  end

  // Delay the expectation so it meets the target's response.
  if (DUT_LAT == 0) begin : g_no_pipe
    always_comb cmp_c = issue_c;
  end else begin : g_pipe
    chk_t pipe_q [DUT_LAT];
    chk_t pipe_d [DUT_LAT];

    always_comb begin
      pipe_d[0] = issue_c;
      for (int unsigned i = 1; i < DUT_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DUT_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    always_comb cmp_c = pipe_q[DUT_LAT-1];
  end

  // Case-inequality so X/Z on the response is a mismatch in simulation.
  assign mismatch_c = cmp_c.valid && (dut_out !== cmp_c.exp);

  // Next-state, stimulus and scoring.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    lfsr_d   = lfsr_q;
    dut_in_d = dut_in_q;
    pass_d   = pass_q;
    err_d    = err_q;
    first_d  = first_q;

    if (mismatch_c) begin
      err_d = (err_q == NO_ERR) ? err_q : err_q + 16'd1;
      if (first_q == NO_ERR) first_d = cmp_c.idx;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          idx_d    = '0;
          lfsr_d   = lfsr_next(SEED);
          dut_in_d = replicate(SEED);
          err_d    = '0;
          first_d  = NO_ERR;
          pass_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (idx_q == LAST_IDX) begin
          if (DUT_LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          idx_d    = idx_q + 16'd1;
          lfsr_d   = lfsr_next(lfsr_q);
          dut_in_d = replicate(lfsr_q);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Includes any mismatch scored on the same edge as entry.
    if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == '0);

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      drain_q  <= '0;
      lfsr_q   <= SEED;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= NO_ERR;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      lfsr_q   <= lfsr_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule
